jtframe_ram_nslots: RTL and testbench

- Parametrised N-slot SDRAM access multiplexer: N request ports to one SDRAM controller port.
- Next generation of the fixed two-slot mux: configurable slot count, fixed-priority or round-robin arbitration, per-slot write enable mask, and an ack/data watchdog.
- Sits between the per-slot request blocks (ROM/RAM request caches) and the SDRAM controller. The request blocks keep caching and latching data. This block owns grant, address/data muxing and completion routing.

---
 rtl/jtframe_ram_nslots.sv | 138 +++++++++++++
 tb/tb_jtframe_ram_nslots.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ram_nslots.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_ram_nslots
//  Description : N-slot SDRAM access multiplexer. Arbitrates SLOTS request
//                ports onto one SDRAM controller port (fixed priority or
//                round-robin), muxes address/data/mask of the granted slot,
//                routes completion strobes back and guards every grant with
//                an ack/data watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_ram_nslots #(
    parameter int               SDRAMW  = 22,
    parameter int               SLOTS   = 4,
    parameter int               RR      = 0,
    parameter logic [SLOTS-1:0] WRSLOTS = 1,
    parameter int               TOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SLOTS-1:0]        slot_req,
    input  logic [SLOTS-1:0]        slot_rnw,
    input  logic [SLOTS*SDRAMW-1:0] slot_addr,
    input  logic [SLOTS*16-1:0]     slot_din,
    input  logic [SLOTS*2-1:0]      slot_wrmask,
    output logic [SLOTS-1:0]        slot_sel,
    output logic [SLOTS-1:0]        slot_rdy,
    output logic [SLOTS-1:0]        slot_dst,
    input  logic                    sdram_ack,
    output logic                    sdram_rd,
    output logic                    sdram_wr,
    output logic [SDRAMW-1:0]       sdram_addr,
    output logic [15:0]             data_write,
    output logic [1:0]              sdram_wrmask,
    input  logic                    data_rdy,
    input  logic                    data_dst,
    output logic                    tout_err,
    output logic                    unexp_err
);

    localparam int c_CW = $clog2(TOUT+1);
    localparam int c_PW = $clog2(SLOTS);

    logic [SLOTS-1:0] w_active;
    logic             w_expire;
    logic             w_arb;
    logic             w_found;
    logic [c_PW-1:0]  w_win;
    logic             w_wren;
    logic             w_wr;
    logic [c_PW-1:0]  r_ptr;
    logic [c_CW-1:0]  r_wd;

    // The slot currently granted is never a candidate, which keeps a
    // completing or timed-out slot out of the very next decision.
    assign w_active = slot_req & ~slot_sel;
    assign w_expire = (slot_sel != '0) && (r_wd == c_CW'(TOUT));
    assign w_arb    = (slot_sel == '0) || data_rdy || w_expire;
    assign w_wren   = WRSLOTS[w_win];
    assign w_wr     = w_wren & ~slot_rnw[w_win];

    assign slot_rdy = data_rdy ? slot_sel : '0;
    assign slot_dst = data_dst ? slot_sel : '0;

    // Winner selection: lowest active index, or first active after the pointer
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        if (RR == 0) begin
            for (int i = SLOTS-1; i >= 0; i--) begin
                if (w_active[i]) begin
                    w_found = 1'b1;
                    w_win   = c_PW'(i);
                end
            end
        end else begin
            for (int j = 0; j < SLOTS; j++) begin
                idx = (int'(r_ptr) + 1 + j) % SLOTS;
                if (!w_found && w_active[idx]) begin
                    w_found = 1'b1;
                    w_win   = c_PW'(idx);
                end
            end
        end
    end

    // Grant register, command muxing, ack handling, watchdog and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_sel     <= '0;
            sdram_rd     <= 1'b0;
            sdram_wr     <= 1'b0;
            sdram_addr   <= '0;
            data_write   <= '0;
            sdram_wrmask <= 2'b11;
            r_ptr        <= c_PW'(SLOTS-1);
            r_wd         <= '0;
            tout_err     <= 1'b0;
            unexp_err    <= 1'b0;
        end else begin
            if (w_arb) begin
                r_wd <= '0;
                if (w_found) begin
                    // A new grant wins over an ack arriving in the same cycle
                    slot_sel     <= SLOTS'(1) << w_win;
                    sdram_addr   <= slot_addr[w_win*SDRAMW +: SDRAMW];
                    data_write   <= slot_din[w_win*16 +: 16];
                    sdram_wrmask <= w_wren ? slot_wrmask[w_win*2 +: 2] : 2'b11;
                    sdram_wr     <= w_wr;
                    sdram_rd     <= ~w_wr;
                    r_ptr        <= w_win;
                end else begin
                    slot_sel     <= '0;
                    sdram_rd     <= 1'b0;
                    sdram_wr     <= 1'b0;
                    sdram_wrmask <= 2'b11;
                end
            end else begin
                if (slot_sel != '0) begin
                    r_wd <= r_wd + c_CW'(1);
                end
                if (sdram_ack) begin
                    sdram_rd <= 1'b0;
                    sdram_wr <= 1'b0;
                end
            end
            if (w_expire) begin
                tout_err <= 1'b1;
            end
            if (data_rdy && (slot_sel == '0)) begin
                unexp_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_ram_nslots.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_ram_nslots
//  Description : Directed bench for jtframe_ram_nslots. A fixed-priority
//                instance (TOUT=8) and a round-robin instance share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_ram_nslots;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  slot_req, slot_rnw;
    logic [87:0] slot_addr;
    logic [63:0] slot_din;
    logic [7:0]  slot_wrmask;
    logic        sdram_ack, data_rdy, data_dst;

    logic [3:0]  sel0, rdy0, dst0, sel1, rdy1, dst1;
    logic        rd0, wr0, te0, ue0, rd1, wr1, te1, ue1;
    logic [21:0] addr0, addr1;
    logic [15:0] dw0, dw1;
    logic [1:0]  wm0, wm1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    jtframe_ram_nslots #(.SDRAMW(22), .SLOTS(4), .RR(0), .WRSLOTS(4'b0001), .TOUT(8)) u0 (
        .clk(clk), .rst(rst), .slot_req(slot_req), .slot_rnw(slot_rnw),
        .slot_addr(slot_addr), .slot_din(slot_din), .slot_wrmask(slot_wrmask),
        .slot_sel(sel0), .slot_rdy(rdy0), .slot_dst(dst0), .sdram_ack(sdram_ack),
        .sdram_rd(rd0), .sdram_wr(wr0), .sdram_addr(addr0), .data_write(dw0),
        .sdram_wrmask(wm0), .data_rdy(data_rdy), .data_dst(data_dst),
        .tout_err(te0), .unexp_err(ue0)
    );

    jtframe_ram_nslots #(.SDRAMW(22), .SLOTS(4), .RR(1), .WRSLOTS(4'b0001), .TOUT(255)) u1 (
        .clk(clk), .rst(rst), .slot_req(slot_req), .slot_rnw(slot_rnw),
        .slot_addr(slot_addr), .slot_din(slot_din), .slot_wrmask(slot_wrmask),
        .slot_sel(sel1), .slot_rdy(rdy1), .slot_dst(dst1), .sdram_ack(sdram_ack),
        .sdram_rd(rd1), .sdram_wr(wr1), .sdram_addr(addr1), .data_write(dw1),
        .sdram_wrmask(wm1), .data_rdy(data_rdy), .data_dst(data_dst),
        .tout_err(te1), .unexp_err(ue1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int order_rr [5];
        int order_fp [5];
        order_rr = '{0, 1, 2, 3, 0};
        order_fp = '{0, 1, 0, 1, 0};

        rst         = 1'b1;
        slot_req    = '0;
        slot_rnw    = 4'b1111;
        slot_addr   = '0;
        slot_din    = '0;
        slot_wrmask = 8'hFF;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        data_dst    = 1'b0;
        tick();
        tick();

        // reset values
        push("rst_sel", 32'h0); push("rst_rd", 32'h0); push("rst_wr", 32'h0);
        push("rst_addr", 32'h0); push("rst_dw", 32'h0); push("rst_wm", 32'h3);
        push("rst_te", 32'h0); push("rst_ue", 32'h0);
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(wr0)); chk(32'(addr0));
        chk(32'(dw0)); chk(32'(wm0)); chk(32'(te0)); chk(32'(ue0));
        rst = 1'b0;
        tick();

        // slots 1 and 3 request at idle: slot 1 wins
        slot_addr[1*22 +: 22] = 22'h100;
        slot_addr[3*22 +: 22] = 22'h300;
        slot_req = 4'b1010;
        push("fp_sel", 32'h2); push("fp_rd", 32'h1); push("fp_addr", 32'h100);
        push("rr_first_sel", 32'h2);
        tick();
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(addr0)); chk(32'(sel1));
        push("rd_held", 32'h1);
        tick();
        chk(32'(rd0));
        // ack in this cycle drops rd on the next
        sdram_ack = 1'b1;
        push("ack_rd_low", 32'h0); push("ack_sel_held", 32'h2);
        tick();
        chk(32'(rd0)); chk(32'(sel0));
        sdram_ack = 1'b0;
        // completion strobes routed only to the granted slot
        data_rdy = 1'b1;
        data_dst = 1'b1;
        #1;
        push("slot_rdy", 32'h2); push("slot_dst", 32'h2);
        chk(32'(rdy0)); chk(32'(dst0));
        push("b2b_sel", 32'h8); push("b2b_rd", 32'h1); push("b2b_addr", 32'h300);
        push("rr_b2b_sel", 32'h8);
        tick();
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(addr0)); chk(32'(sel1));
        data_dst = 1'b0;
        slot_req = 4'b0000;
        push("release_sel", 32'h0); push("release_rd", 32'h0); push("release_ue", 32'h0);
        tick();
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(ue0));
        data_rdy = 1'b0;

        // writes: slot 0 allowed, slot 2 demoted to read
        do_reset();
        slot_din[0*16 +: 16]   = 16'hBEEF;
        slot_din[2*16 +: 16]   = 16'hBEEF;
        slot_wrmask[0*2 +: 2]  = 2'b10;
        slot_wrmask[2*2 +: 2]  = 2'b10;
        slot_rnw = 4'b1010;
        slot_req = 4'b0001;
        push("w0_wr", 32'h1); push("w0_rd", 32'h0); push("w0_dw", 32'hBEEF); push("w0_wm", 32'h2);
        tick();
        chk(32'(wr0)); chk(32'(rd0)); chk(32'(dw0)); chk(32'(wm0));
        slot_req = 4'b0100;
        data_rdy = 1'b1;
        push("w2_sel", 32'h4); push("w2_rd", 32'h1); push("w2_wr", 32'h0);
        push("w2_wm", 32'h3); push("w2_dw", 32'hBEEF);
        tick();
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(wr0)); chk(32'(wm0)); chk(32'(dw0));
        data_rdy = 1'b0;
        slot_req = 4'b0000;
        slot_rnw = 4'b1111;

        // continuous requests, completion every 4 cycles
        do_reset();
        slot_req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            push($sformatf("rr_grant%0d", g), 32'(4'b0001 << order_rr[g]));
            push($sformatf("fp_grant%0d", g), 32'(4'b0001 << order_fp[g]));
            chk(32'(sel1));
            chk(32'(sel0));
            tick(); tick(); tick();
            data_rdy = 1'b1;
            tick();
            data_rdy = 1'b0;
        end
        slot_req = 4'b0000;

        // watchdog: slot 1 never completes, slot 2 pending
        do_reset();
        slot_req = 4'b0010;
        tick();
        slot_req = 4'b0110;
        for (int c = 0; c < 7; c++) tick();
        push("wd_before_sel", 32'h2); push("wd_before_te", 32'h0);
        tick();
        chk(32'(sel0)); chk(32'(te0));
        push("wd_after_sel", 32'h4); push("wd_after_te", 32'h1); push("wd_after_rd", 32'h1);
        tick();
        chk(32'(sel0)); chk(32'(te0)); chk(32'(rd0));
        slot_req = 4'b0000;

        // reset mid-read, then a stray data_rdy
        do_reset();
        slot_addr[0*22 +: 22] = 22'h55;
        slot_req = 4'b0001;
        push("pre_sel", 32'h1); push("pre_rd", 32'h1);
        tick();
        chk(32'(sel0)); chk(32'(rd0));
        rst = 1'b1;
        #1;
        push("async_sel", 32'h0); push("async_rd", 32'h0); push("async_te", 32'h0);
        chk(32'(sel0)); chk(32'(rd0)); chk(32'(te0));
        #1;
        rst = 1'b0;
        slot_req = 4'b0000;
        data_rdy = 1'b1;
        #1;
        push("stray_rdy", 32'h0);
        chk(32'(rdy0));
        push("stray_ue", 32'h1); push("stray_sel", 32'h0); push("stray_wm", 32'h3);
        push("stray_addr", 32'h0); push("stray_rd", 32'h0);
        tick();
        chk(32'(ue0)); chk(32'(sel0)); chk(32'(wm0)); chk(32'(addr0)); chk(32'(rd0));
        data_rdy = 1'b0;
        push("ue_sticky", 32'h1);
        tick();
        chk(32'(ue0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
